// File: rtl/range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : range_tracker
// Purpose  : Tracks the running maximum, minimum and accepted-sample count of
//            a framed sample stream delimited by go/finish. At frame end it
//            publishes registered max, min, range (max - min, WIDTH+1 bits,
//            never negative), a saturating count and a one-cycle done strobe.
//            Protocol violations enter a latched error state that is left
//            only by a legal go.
// Ports    : clock      - sole clock, rising edge
//            reset      - synchronous, active-high reset
//            data_in    - sample (WIDTH bits)
//            data_valid - qualifies data_in this cycle (ignored on the go cycle)
//            go         - frame start; data_in that cycle is the first sample
//            finish     - frame end; data_in that cycle counts if data_valid
//            max_out    - frame maximum
//            min_out    - frame minimum
//            range      - max - min, WIDTH+1 bits
//            count      - accepted samples in frame, saturating
//            count_sat  - counter saturated during the frame
//            done       - one-cycle result strobe
//            error      - latched protocol error
// Revision : 1.0 - initial release
// ============================================================================
module range_tracker #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int SIGNED      = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_valid,
  input  logic                   go,
  input  logic                   finish,
  output logic [WIDTH-1:0]       max_out,
  output logic [WIDTH-1:0]       min_out,
  output logic [WIDTH:0]         range,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   count_sat,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_go_prev;
  logic [WIDTH-1:0]       r_max;
  logic [WIDTH-1:0]       r_min;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic                   r_sat;

  logic [WIDTH-1:0]       r_max_out;
  logic [WIDTH-1:0]       r_min_out;
  logic [WIDTH:0]         r_range;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_sat;
  logic                   r_done;
  logic                   r_error;

  logic                   w_go_rise;
  logic                   w_gt;
  logic                   w_lt;
  logic                   w_cnt_full;
  logic [WIDTH-1:0]       w_max_nxt;
  logic [WIDTH-1:0]       w_min_nxt;
  logic [COUNT_WIDTH-1:0] w_cnt_nxt;
  logic                   w_sat_nxt;
  logic [WIDTH:0]         w_max_ext;
  logic [WIDTH:0]         w_min_ext;
  logic [WIDTH:0]         w_range_nxt;

  // Only a fresh go edge aborts a running frame; go held high is harmless.
  assign w_go_rise = go & ~r_go_prev;

  assign w_gt = (SIGNED != 0) ? ($signed(data_in) > $signed(r_max))
                              : (data_in > r_max);
  assign w_lt = (SIGNED != 0) ? ($signed(data_in) < $signed(r_min))
                              : (data_in < r_min);

  assign w_cnt_full = &r_cnt;

  // Post-update frame values; these feed both the running registers and,
  // on the finish cycle, the result registers.
  assign w_max_nxt = (data_valid && w_gt) ? data_in : r_max;
  assign w_min_nxt = (data_valid && w_lt) ? data_in : r_min;
  assign w_cnt_nxt = (data_valid && !w_cnt_full) ? r_cnt + COUNT_WIDTH'(1) : r_cnt;
  // Saturation flags a sample that could not be counted.
  assign w_sat_nxt = r_sat | (data_valid & w_cnt_full);

  // One extra bit keeps max - min non-negative for the full input span.
  assign w_max_ext   = {((SIGNED != 0) ? w_max_nxt[WIDTH-1] : 1'b0), w_max_nxt};
  assign w_min_ext   = {((SIGNED != 0) ? w_min_nxt[WIDTH-1] : 1'b0), w_min_nxt};
  assign w_range_nxt = w_max_ext - w_min_ext;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_go_prev   <= 1'b0;
      r_max       <= '0;
      r_min       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_max_out   <= '0;
      r_min_out   <= '0;
      r_range     <= '0;
      r_count     <= '0;
      r_count_sat <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_go_prev <= go;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (go && !finish) begin
            // The go sample is always accepted regardless of data_valid.
            r_state <= S_RUN;
            r_max   <= data_in;
            r_min   <= data_in;
            r_cnt   <= COUNT_WIDTH'(1);
            r_sat   <= 1'b0;
            r_error <= 1'b0;
          end else if (finish) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_go_rise) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
            r_cnt <= w_cnt_nxt;
            r_sat <= w_sat_nxt;
            if (finish) begin
              r_max_out   <= w_max_nxt;
              r_min_out   <= w_min_nxt;
              r_range     <= w_range_nxt;
              r_count     <= w_cnt_nxt;
              r_count_sat <= w_sat_nxt;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign max_out   = r_max_out;
  assign min_out   = r_min_out;
  assign range     = r_range;
  assign count     = r_count;
  assign count_sat = r_count_sat;
  assign done      = r_done;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_range_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_tracker
// Purpose  : Directed self-checking bench for range_tracker. Three instances
//            share one stimulus stream: unsigned 8-bit, signed 8-bit, and
//            unsigned 8-bit with a 3-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_tracker;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       go;
  logic       finish;

  logic [7:0] u_max, u_min, s_max, s_min, c_max, c_min;
  logic [8:0] u_rng, s_rng, c_rng;
  logic [7:0] u_cnt, s_cnt;
  logic [2:0] c_cnt;
  logic       u_sat, s_sat, c_sat;
  logic       u_done, s_done, c_done;
  logic       u_err, s_err, c_err;

  int checks;
  int failures;

  range_tracker #(.WIDTH(8), .COUNT_WIDTH(8), .SIGNED(0)) u_dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .max_out(u_max), .min_out(u_min), .range(u_rng),
    .count(u_cnt), .count_sat(u_sat), .done(u_done), .error(u_err));

  range_tracker #(.WIDTH(8), .COUNT_WIDTH(8), .SIGNED(1)) u_sgn (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .max_out(s_max), .min_out(s_min), .range(s_rng),
    .count(s_cnt), .count_sat(s_sat), .done(s_done), .error(s_err));

  range_tracker #(.WIDTH(8), .COUNT_WIDTH(3), .SIGNED(0)) u_cw3 (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .max_out(c_max), .min_out(c_min), .range(c_rng),
    .count(c_cnt), .count_sat(c_sat), .done(c_done), .error(c_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic g, input logic f, input logic v, input logic [7:0] d);
    go = g; finish = f; data_valid = v; data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    checks++; if (u_max  !== 8'd0) begin failures++; $display("FAIL reset_max: got %0d want 0", u_max); end
    checks++; if (u_min  !== 8'd0) begin failures++; $display("FAIL reset_min: got %0d want 0", u_min); end
    checks++; if (u_rng  !== 9'd0) begin failures++; $display("FAIL reset_range: got %0d want 0", u_rng); end
    checks++; if (u_cnt  !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", u_cnt); end
    checks++; if ({u_sat, u_done, u_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {u_sat, u_done, u_err}); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    step(1'b1, 1'b0, 1'b0, 8'd20);
    step(1'b0, 1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 1'b1, 8'd200);
    step(1'b0, 1'b0, 1'b1, 8'd90);
    checks++; if (u_done !== 1'b0) begin failures++; $display("FAIL uns_early_done: got %b want 0", u_done); end
    step(1'b0, 1'b1, 1'b1, 8'd7);
    checks++; if (u_done !== 1'b1)   begin failures++; $display("FAIL uns_done: got %b want 1", u_done); end
    checks++; if (u_max  !== 8'd200) begin failures++; $display("FAIL uns_max: got %0d want 200", u_max); end
    checks++; if (u_min  !== 8'd5)   begin failures++; $display("FAIL uns_min: got %0d want 5", u_min); end
    checks++; if (u_rng  !== 9'd195) begin failures++; $display("FAIL uns_range: got %0d want 195", u_rng); end
    checks++; if (u_cnt  !== 8'd5)   begin failures++; $display("FAIL uns_count: got %0d want 5", u_cnt); end
    step(1'b0, 1'b0, 1'b0, 8'd0);
    checks++; if (u_done !== 1'b0)   begin failures++; $display("FAIL uns_done_pulse: got %b want 0", u_done); end
    checks++; if (u_max  !== 8'd200) begin failures++; $display("FAIL uns_hold_max: got %0d want 200", u_max); end
  endtask

  task automatic test_signed();
    step(1'b1, 1'b0, 1'b0, 8'h9C);   // -100
    step(1'b0, 1'b0, 1'b1, 8'd27);
    step(1'b0, 1'b0, 1'b1, 8'h80);   // -128
    step(1'b0, 1'b1, 1'b1, 8'h7F);   // 127
    checks++; if (s_done !== 1'b1)   begin failures++; $display("FAIL sgn_done: got %b want 1", s_done); end
    checks++; if (s_max  !== 8'h7F)  begin failures++; $display("FAIL sgn_max: got %h want 7f", s_max); end
    checks++; if (s_min  !== 8'h80)  begin failures++; $display("FAIL sgn_min: got %h want 80", s_min); end
    checks++; if (s_rng  !== 9'd255) begin failures++; $display("FAIL sgn_range: got %0d want 255", s_rng); end
    // Same bytes viewed unsigned: 156, 27, 128, 127.
    checks++; if (u_max  !== 8'd156) begin failures++; $display("FAIL sgn_as_uns_max: got %0d want 156", u_max); end
    checks++; if (u_rng  !== 9'd129) begin failures++; $display("FAIL sgn_as_uns_range: got %0d want 129", u_rng); end
  endtask

  task automatic test_valid_gaps();
    step(1'b1, 1'b0, 1'b0, 8'd50);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd255);
    step(1'b0, 1'b0, 1'b1, 8'd60);
    step(1'b0, 1'b1, 1'b0, 8'd1);
    checks++; if (u_done !== 1'b1)  begin failures++; $display("FAIL gap_done: got %b want 1", u_done); end
    checks++; if (u_max  !== 8'd60) begin failures++; $display("FAIL gap_max: got %0d want 60", u_max); end
    checks++; if (u_min  !== 8'd50) begin failures++; $display("FAIL gap_min: got %0d want 50", u_min); end
    checks++; if (u_rng  !== 9'd10) begin failures++; $display("FAIL gap_range: got %0d want 10", u_rng); end
    checks++; if (u_cnt  !== 8'd2)  begin failures++; $display("FAIL gap_count: got %0d want 2", u_cnt); end
  endtask

  task automatic test_errors();
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);    // finish in IDLE
    checks++; if (u_err !== 1'b1) begin failures++; $display("FAIL err_finish_idle: got %b want 1", u_err); end
    step(1'b1, 1'b1, 1'b0, 8'd0);    // go+finish in ERR
    checks++; if (u_err !== 1'b1) begin failures++; $display("FAIL err_gofin_hold: got %b want 1", u_err); end
    step(1'b1, 1'b0, 1'b0, 8'd33);   // legal go recovers
    checks++; if (u_err !== 1'b0) begin failures++; $display("FAIL err_recover: got %b want 0", u_err); end
    step(1'b1, 1'b0, 1'b1, 8'd40);   // go held high: no effect
    checks++; if (u_err !== 1'b0) begin failures++; $display("FAIL err_go_held: got %b want 0", u_err); end
    step(1'b0, 1'b0, 1'b1, 8'd10);
    step(1'b1, 1'b0, 1'b1, 8'd99);   // go re-asserted mid-frame
    checks++; if (u_err !== 1'b1) begin failures++; $display("FAIL err_go_rise: got %b want 1", u_err); end
    step(1'b0, 1'b1, 1'b1, 8'd0);
    checks++; if (u_done !== 1'b0) begin failures++; $display("FAIL err_no_done: got %b want 0", u_done); end
    checks++; if (u_max !== 8'd60 || u_cnt !== 8'd2) begin failures++; $display("FAIL err_results_held: got max=%0d cnt=%0d want max=60 cnt=2", u_max, u_cnt); end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b1, 8'd1);    // leaves ERR
    checks++; if (c_err !== 1'b0) begin failures++; $display("FAIL sat_err_clear: got %b want 0", c_err); end
    for (int i = 2; i <= 9; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b1, 1'b1, 8'd10);
    checks++; if (c_cnt !== 3'd7)  begin failures++; $display("FAIL sat_count: got %0d want 7", c_cnt); end
    checks++; if (c_sat !== 1'b1)  begin failures++; $display("FAIL sat_flag: got %b want 1", c_sat); end
    checks++; if (u_cnt !== 8'd10 || u_sat !== 1'b0) begin failures++; $display("FAIL sat_wide_count: got cnt=%0d sat=%b want cnt=10 sat=0", u_cnt, u_sat); end
    checks++; if (c_rng !== 9'd9)  begin failures++; $display("FAIL sat_range: got %0d want 9", c_rng); end
    step(1'b1, 1'b0, 1'b1, 8'd3);    // go on the done cycle's successor
    step(1'b0, 1'b1, 1'b1, 8'd4);
    checks++; if (c_done !== 1'b1) begin failures++; $display("FAIL sat2_done: got %b want 1", c_done); end
    checks++; if (c_cnt !== 3'd2 || c_sat !== 1'b0) begin failures++; $display("FAIL sat2_count: got cnt=%0d sat=%b want cnt=2 sat=0", c_cnt, c_sat); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b1, 8'd10);
    step(1'b0, 1'b0, 1'b1, 8'd20);
    step(1'b0, 1'b0, 1'b1, 8'd30);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'd40);
    checks++; if ({u_max, u_min, u_cnt} !== 24'd0 || u_rng !== 9'd0) begin failures++; $display("FAIL rstmid_outputs: got max=%0d min=%0d rng=%0d cnt=%0d want 0", u_max, u_min, u_rng, u_cnt); end
    checks++; if ({u_done, u_err, u_sat} !== 3'b000) begin failures++; $display("FAIL rstmid_flags: got %b want 000", {u_done, u_err, u_sat}); end
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'd0);
    checks++; if (u_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done: got %b want 0", u_done); end
  endtask

  task automatic test_back_to_back();
    // Single-sample frame.
    step(1'b1, 1'b0, 1'b1, 8'd77);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    checks++; if (u_done !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", u_done); end
    checks++; if (u_cnt !== 8'd1 || u_rng !== 9'd0 || u_max !== 8'd77) begin failures++; $display("FAIL single_result: got cnt=%0d rng=%0d max=%0d want 1 0 77", u_cnt, u_rng, u_max); end
    // Next frame starts immediately, no gap.
    step(1'b1, 1'b0, 1'b0, 8'd100);
    checks++; if (u_done !== 1'b0) begin failures++; $display("FAIL b2b_pulse: got %b want 0", u_done); end
    step(1'b0, 1'b1, 1'b1, 8'd150);
    checks++; if (u_done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", u_done); end
    checks++; if (u_max !== 8'd150 || u_min !== 8'd100) begin failures++; $display("FAIL b2b_maxmin: got %0d/%0d want 150/100", u_max, u_min); end
    checks++; if (u_rng !== 9'd50 || u_cnt !== 8'd2) begin failures++; $display("FAIL b2b_range_count: got %0d/%0d want 50/2", u_rng, u_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; go = 1'b0; finish = 1'b0; data_valid = 1'b0; data_in = 8'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_valid_gaps();
    test_errors();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
